// File: rtl/gsense_rx_train_ctrl.sv
// Shared training sequencer for the GSENSE LVDS lanes: per-lane tap-window scan,
// centring, bitslip alignment, lock verification and post-lock monitoring/retrain.
module gsense_rx_train_ctrl #(
    parameter int unsigned LANES      = 4,
    parameter int unsigned DATA_BITS  = 12,
    parameter int unsigned TAP_BITS   = 5,
    parameter int unsigned MIN_WINDOW = 8,
    parameter int unsigned SETTLE     = 16,
    parameter int unsigned LOCK_CHECK = 64,
    parameter int unsigned ERR_LIMIT  = 4,
    parameter int unsigned RETRIES    = 2
) (
    input  logic                       clkdiv,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       in_train,
    input  logic [DATA_BITS-1:0]       training_pattern,
    input  logic [LANES*DATA_BITS-1:0] word,
    input  logic [LANES-1:0]           word_valid,
    output logic [LANES-1:0]           dly_rst,
    output logic [LANES-1:0]           dly_inc,
    output logic [LANES-1:0]           bitslip,
    output logic [LANES-1:0]           lane_locked,
    output logic [LANES-1:0]           lane_fail,
    output logic                       all_locked,
    output logic                       busy,
    output logic [7:0]                 dbg_lane,
    output logic [TAP_BITS-1:0]        dbg_tap
);
    localparam int unsigned WIN_W   = TAP_BITS + 1;
    localparam int unsigned CNT_MAX = (LOCK_CHECK > SETTLE) ? LOCK_CHECK : SETTLE;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam int unsigned SLIP_W  = $clog2(DATA_BITS + 1);
    localparam int unsigned RTY_W   = $clog2(RETRIES + 1);
    localparam int unsigned ERR_W   = $clog2(ERR_LIMIT + 1);
    localparam logic [CNT_W-1:0]    SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0]    LOCK_LAST   = CNT_W'(LOCK_CHECK - 1);
    localparam logic [ERR_W-1:0]    ERR_LAST    = ERR_W'(ERR_LIMIT - 1);
    localparam logic [TAP_BITS-1:0] TAP_MAX     = '1;

    typedef enum logic [3:0] {
        ST_IDLE, ST_RST, ST_SCAN_SETTLE, ST_SCAN_CHECK, ST_SCAN_STEP, ST_SEEK,
        ST_SLIP, ST_SLIP_CHECK, ST_VERIFY, ST_NEXT, ST_MONITOR
    } state_t;

    state_t               r_state;
    logic [7:0]           r_lane;
    logic [TAP_BITS-1:0]  r_tap;
    logic [1:0]           r_sub;
    logic [CNT_W-1:0]     r_cnt;
    logic [DATA_BITS-1:0] r_ref;
    logic                 r_have_ref;
    logic                 r_stable;
    logic [TAP_BITS-1:0]  r_cur_start;
    logic [WIN_W-1:0]     r_cur_len;
    logic [TAP_BITS-1:0]  r_best_start;
    logic [WIN_W-1:0]     r_best_len;
    logic [WIN_W-1:0]     r_target;
    logic [SLIP_W-1:0]    r_slips;
    logic [RTY_W-1:0]     r_retry;
    logic                 r_mon;
    logic [LANES-1:0]     r_req;
    logic [ERR_W-1:0]     r_err [LANES];
    logic [LANES-1:0]     r_dly_rst, r_dly_inc, r_bitslip, r_locked, r_fail;
    logic                 r_all_locked, r_busy;

    logic [DATA_BITS-1:0] w_cur_word;
    logic                 w_cur_valid;
    logic                 w_cur_match;
    logic                 w_stable_now;
    logic                 w_retry_last;
    logic                 w_fail_evt;
    logic [LANES-1:0]     w_mon_match;
    logic                 w_req_any;
    logic [7:0]           w_req_idx;
    logic [7:0]           w_next_lane;

    function automatic logic [LANES-1:0] lane_bit(input logic [7:0] idx);
        lane_bit = '0;
        for (int i = 0; i < LANES; i++) begin
            if (idx == 8'(i)) lane_bit[i] = 1'b1;
        end
    endfunction

    // Current-lane word select, per-lane monitor compare, lowest pending retrain request
    always_comb begin
        w_cur_word  = '0;
        w_cur_valid = 1'b0;
        w_mon_match = '0;
        w_req_idx   = '0;
        for (int i = 0; i < LANES; i++) begin
            w_mon_match[i] = (word[i*DATA_BITS +: DATA_BITS] == training_pattern);
            if (r_lane == 8'(i)) begin
                w_cur_word  = word[i*DATA_BITS +: DATA_BITS];
                w_cur_valid = word_valid[i];
            end
        end
        for (int i = LANES - 1; i >= 0; i--) begin
            if (r_req[i]) w_req_idx = 8'(i);
        end
    end

    assign w_req_any    = |r_req;
    assign w_next_lane  = r_lane + 8'd1;
    assign w_cur_match  = (w_cur_word == training_pattern);
    assign w_stable_now = r_stable && (w_cur_word == r_ref);
    assign w_retry_last = (32'(r_retry) + 32'd1) >= RETRIES;

    // Any event that sends the current lane down the retry path
    always_comb begin
        w_fail_evt = 1'b0;
        case (r_state)
            ST_SEEK:       w_fail_evt = (r_sub == 2'd0) && (r_best_len < WIN_W'(MIN_WINDOW));
            ST_SLIP_CHECK: w_fail_evt = w_cur_valid && !w_cur_match && (r_slips == SLIP_W'(DATA_BITS));
            ST_VERIFY:     w_fail_evt = w_cur_valid && !w_cur_match;
            default:       w_fail_evt = 1'b0;
        endcase
    end

    always_ff @(posedge clkdiv or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_lane       <= '0;
            r_tap        <= '0;
            r_sub        <= '0;
            r_cnt        <= '0;
            r_ref        <= '0;
            r_have_ref   <= 1'b0;
            r_stable     <= 1'b0;
            r_cur_start  <= '0;
            r_cur_len    <= '0;
            r_best_start <= '0;
            r_best_len   <= '0;
            r_target     <= '0;
            r_slips      <= '0;
            r_retry      <= '0;
            r_mon        <= 1'b0;
            r_req        <= '0;
            for (int i = 0; i < LANES; i++) r_err[i] <= '0;
            r_dly_rst    <= '0;
            r_dly_inc    <= '0;
            r_bitslip    <= '0;
            r_locked     <= '0;
            r_fail       <= '0;
            r_all_locked <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_dly_rst    <= '0;
            r_dly_inc    <= '0;
            r_bitslip    <= '0;
            r_all_locked <= (&(r_locked | r_fail)) && (|r_locked);
            if (w_fail_evt) begin
                r_retry <= r_retry + RTY_W'(1);
                if (w_retry_last) begin
                    r_fail  <= r_fail | lane_bit(r_lane);
                    r_state <= r_mon ? ST_MONITOR : ST_NEXT;
                    r_busy  <= !r_mon;
                end else begin
                    r_state   <= ST_RST;
                    r_sub     <= '0;
                    r_dly_rst <= lane_bit(r_lane);
                end
            end else begin
                case (r_state)
                    ST_IDLE: if (start) begin
                        r_lane    <= '0;
                        r_retry   <= '0;
                        r_mon     <= 1'b0;
                        r_req     <= '0;
                        r_locked  <= r_locked & ~lane_bit(8'd0);
                        r_dly_rst <= lane_bit(8'd0);
                        r_sub     <= '0;
                        r_busy    <= 1'b1;
                        r_state   <= ST_RST;
                    end
                    ST_RST: if (r_sub == 2'd0) begin
                        r_dly_rst <= lane_bit(r_lane);
                        r_sub     <= 2'd1;
                    end else begin
                        r_tap        <= '0;
                        r_cnt        <= '0;
                        r_cur_len    <= '0;
                        r_cur_start  <= '0;
                        r_best_len   <= '0;
                        r_best_start <= '0;
                        r_slips      <= '0;
                        r_state      <= ST_SCAN_SETTLE;
                    end
                    ST_SCAN_SETTLE: if (w_cur_valid) begin
                        if (r_cnt == SETTLE_LAST) begin
                            r_cnt      <= '0;
                            r_have_ref <= 1'b0;
                            r_state    <= ST_SCAN_CHECK;
                        end else r_cnt <= r_cnt + CNT_W'(1);
                    end
                    ST_SCAN_CHECK: if (w_cur_valid) begin
                        if (!r_have_ref) begin
                            r_ref      <= w_cur_word;
                            r_have_ref <= 1'b1;
                            r_stable   <= 1'b1;
                            r_cnt      <= '0;
                        end else if (r_cnt == SETTLE_LAST) begin
                            if (w_stable_now) begin
                                if (r_cur_len == '0) r_cur_start <= r_tap;
                                r_cur_len <= r_cur_len + WIN_W'(1);
                            end else begin
                                if (r_cur_len > r_best_len) begin
                                    r_best_len   <= r_cur_len;
                                    r_best_start <= r_cur_start;
                                end
                                r_cur_len <= '0;
                            end
                            r_state <= ST_SCAN_STEP;
                        end else begin
                            r_cnt <= r_cnt + CNT_W'(1);
                            if (w_cur_word != r_ref) r_stable <= 1'b0;
                        end
                    end
                    ST_SCAN_STEP: if (r_tap == TAP_MAX) begin
                        if (r_cur_len > r_best_len) begin
                            r_best_len   <= r_cur_len;
                            r_best_start <= r_cur_start;
                        end
                        r_sub   <= '0;
                        r_state <= ST_SEEK;
                    end else begin
                        r_dly_inc <= lane_bit(r_lane);
                        r_tap     <= r_tap + TAP_BITS'(1);
                        r_cnt     <= '0;
                        r_state   <= ST_SCAN_SETTLE;
                    end
                    // Return to tap 0, then step up to the window centre at one tap per 2 cycles
                    ST_SEEK: case (r_sub)
                        2'd0: begin
                            r_target  <= WIN_W'(r_best_start) + (r_best_len >> 1);
                            r_dly_rst <= lane_bit(r_lane);
                            r_tap     <= '0;
                            r_sub     <= 2'd1;
                        end
                        2'd1: r_sub <= 2'd2;
                        2'd2: if ({1'b0, r_tap} == r_target) begin
                            r_cnt <= '0;
                            r_sub <= 2'd3;
                        end else begin
                            r_dly_inc <= lane_bit(r_lane);
                            r_tap     <= r_tap + TAP_BITS'(1);
                            r_sub     <= 2'd1;
                        end
                        default: if (w_cur_valid) begin
                            if (r_cnt == SETTLE_LAST) r_state <= ST_SLIP_CHECK;
                            else r_cnt <= r_cnt + CNT_W'(1);
                        end
                    endcase
                    ST_SLIP_CHECK: if (w_cur_valid) begin
                        r_cnt   <= '0;
                        r_sub   <= '0;
                        r_state <= w_cur_match ? ST_VERIFY : ST_SLIP;
                    end
                    ST_SLIP: if (r_sub == 2'd0) begin
                        r_bitslip <= lane_bit(r_lane);
                        r_slips   <= r_slips + SLIP_W'(1);
                        r_cnt     <= '0;
                        r_sub     <= 2'd1;
                    end else if (w_cur_valid) begin
                        if (r_cnt == SETTLE_LAST) r_state <= ST_SLIP_CHECK;
                        else r_cnt <= r_cnt + CNT_W'(1);
                    end
                    ST_VERIFY: if (w_cur_valid) begin
                        if (r_cnt == LOCK_LAST) begin
                            r_locked <= r_locked | lane_bit(r_lane);
                            r_state  <= r_mon ? ST_MONITOR : ST_NEXT;
                            r_busy   <= !r_mon;
                        end else r_cnt <= r_cnt + CNT_W'(1);
                    end
                    ST_NEXT: if (r_lane == 8'(LANES - 1)) begin
                        for (int i = 0; i < LANES; i++) r_err[i] <= '0;
                        r_busy  <= 1'b0;
                        r_state <= ST_MONITOR;
                    end else begin
                        r_lane    <= w_next_lane;
                        r_retry   <= '0;
                        r_locked  <= r_locked & ~lane_bit(w_next_lane);
                        r_dly_rst <= lane_bit(w_next_lane);
                        r_sub     <= '0;
                        r_state   <= ST_RST;
                    end
                    ST_MONITOR: if (!start) begin
                        r_state <= ST_IDLE;
                    end else begin
                        for (int i = 0; i < LANES; i++) begin
                            if (r_locked[i] && in_train && word_valid[i]) begin
                                if (w_mon_match[i]) r_err[i] <= '0;
                                else if (r_err[i] == ERR_LAST) begin
                                    r_err[i]    <= '0;
                                    r_locked[i] <= 1'b0;
                                    r_req[i]    <= 1'b1;
                                end else r_err[i] <= r_err[i] + ERR_W'(1);
                            end
                        end
                        if (w_req_any) begin
                            r_lane    <= w_req_idx;
                            r_req     <= r_req & ~lane_bit(w_req_idx);
                            r_retry   <= '0;
                            r_mon     <= 1'b1;
                            r_dly_rst <= lane_bit(w_req_idx);
                            r_sub     <= '0;
                            r_busy    <= 1'b1;
                            r_state   <= ST_RST;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign dly_rst     = r_dly_rst;
    assign dly_inc     = r_dly_inc;
    assign bitslip     = r_bitslip;
    assign lane_locked = r_locked;
    assign lane_fail   = r_fail;
    assign all_locked  = r_all_locked;
    assign busy        = r_busy;
    assign dbg_lane    = r_lane;
    assign dbg_tap     = r_tap;
endmodule
